sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
- Produces the 8-bit master timing sequence S[7:0] consumed by the sequence decoder.
- S is an 8-stage Johnson (twisted-ring) counter advanced by the 16 MHz clock, giving a 16-state, 1 µs cycle.
- Adds a phase index, a cycle-start strobe, a microsecond counter, external phase resynchronisation and recovery from illegal states.
- Sits between the clock input and the sequence decoder / video timing blocks.

Parameters:
- SYNC_PHASE, 0, phase index (0..15) loaded when SYNC is asserted.
- US_MOD, 64, modulus of the microsecond counter US_CNT (2..256).
- US_W, 8, width of US_CNT; must satisfy 2^US_W >= US_MOD.

Ports:
- CLK_n  in  1  16 MHz master clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CE  in  1  clock enable; sequencer advances only when 1.
- SYNC  in  1  phase realign request.
- S  out  8  Johnson sequence state.
- PHASE  out  4  phase index 0..15 of the current S.
- CYC_START  out  1  high while PHASE==0 and CE==1.
- US_CNT  out  US_W  microsecond counter, increments on each completed 16-phase cycle.
- SEQ_ERR  out  1  one-clock pulse when an illegal S was detected and corrected.

Behaviour:
- Reset: on a CLK_n rise with RESET=1, S=8'h00, US_CNT=0, SEQ_ERR=0.
  - Consequently PHASE=0 and CYC_START=CE.
  - RESET overrides CE, SYNC and error recovery.
- Legal sequence (16 states):
  - Phase p in 0..8: S has bits [p-1:0] set and all others clear.
  - Phase p in 9..15: S has bits [7:p-8] set and bits [p-9:0] clear.
  - Full sequence: 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80, then wraps to 00.
- Advance: with CE=1, SYNC=0 and S legal, next S = {S[6:0], ~S[7]}.
  - With CE=0, S and US_CNT hold, and SEQ_ERR is 0.
- PHASE: combinational encoding of S per the table above.
  - PHASE is 0 whenever S is illegal; SEQ_ERR then flags the condition on the following edge.
- SYNC: with CE=1 and SYNC=1, next S is the legal pattern for SYNC_PHASE, regardless of the current state.
  - US_CNT is not incremented on a SYNC load, even when leaving phase 15.
  - SYNC held high re-loads SYNC_PHASE every enabled clock.
  - SYNC with CE=0 is ignored.
- Illegal state: a pattern not among the 16 legal patterns.
  - With CE=1 and SYNC=0, next S=8'h00, and SEQ_ERR=1 for exactly that one clock (registered).
  - SYNC takes priority over recovery, and SEQ_ERR stays 0 in that case.
- US_CNT: increments when CE=1, SYNC=0 and the current PHASE is 15 with S legal (the transition 80->00).
  - Wraps from US_MOD-1 to 0.
- CYC_START: combinational, (PHASE==0) & (S==8'h00) & CE.
- Latency: S, US_CNT and SEQ_ERR are registered (one clock); PHASE and CYC_START are combinational from S.
- Reset mid-cycle: at any phase, next S=00 and US_CNT=0; no SEQ_ERR pulse.
- Single-bit invariant: with CE=1 and no SYNC or illegal state, exactly one bit of S changes per clock.

Test Plan:
- Reset then CE=1 for 32 clocks -> S walks 00,01,03,...,FF,FE,...,80,00 twice; PHASE 0..15,0..15; US_CNT=2; CYC_START high on clocks 0 and 16 only.
- CE toggled 1,0,0,1 starting at S=07 -> S 07->0F, held at 0F for two clocks, then 1F; US_CNT unchanged.
- SYNC_PHASE=8, SYNC pulsed at S=3F -> next S=FF, PHASE=8; US_CNT unchanged; SYNC asserted at S=80 -> next S=FF and US_CNT not incremented.
- Force illegal S=8'h5A (bench force/release) -> next clock S=00, SEQ_ERR=1 for one clock, then 01 with SEQ_ERR=0; same injection with SYNC=1 -> S=SYNC_PHASE pattern, SEQ_ERR=0.
- US_MOD=4: run 5 full cycles -> US_CNT sequence 1,2,3,0,1; RESET asserted at S=F0 -> next S=00, US_CNT=0, SEQ_ERR=0.
- Random CE/SYNC for 10k clocks -> PHASE always matches S per the table; at most one S bit changes per clock except on SYNC loads; SEQ_ERR never asserts.

Source files
------------

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : sequence_generator
// Function : 8-stage Johnson counter producing the 16-state master timing
//            sequence, with phase decode, cycle-start strobe, microsecond
//            counter, external resync and illegal-state recovery.
// Revision : 1.0  initial release
// ============================================================================
module sequence_generator #(
    parameter int SYNC_PHASE = 0,
    parameter int US_MOD     = 64,
    parameter int US_W       = 8
) (
    input  logic            CLK_n,
    input  logic            RESET,
    input  logic            CE,
    input  logic            SYNC,
    output logic [7:0]      S,
    output logic [3:0]      PHASE,
    output logic            CYC_START,
    output logic [US_W-1:0] US_CNT,
    output logic            SEQ_ERR
);

    // Legal Johnson pattern for a phase index: a run of ones filling from
    // bit 0 for phases 0..8, then a run of zeros filling from bit 0.
    function automatic logic [7:0] johnson_pattern(input logic [3:0] p);
        logic [7:0] ones;
        ones = 8'hFF;
        if (p <= 4'd8) begin
            johnson_pattern = ~(ones << p);
        end else begin
            johnson_pattern = ones << (p - 4'd8);
        end
    endfunction

    localparam logic [7:0]      c_sync_pat = johnson_pattern(4'(SYNC_PHASE));
    localparam logic [US_W-1:0] c_us_last  = US_W'(US_MOD - 1);

    logic [7:0]      r_s;
    logic [US_W-1:0] r_us_cnt;
    logic            r_seq_err;
    logic [3:0]      w_phase;
    logic            w_legal;

    // Decode the current state into a phase index and a legality flag.
    always_comb begin
        w_phase = 4'd0;
        w_legal = 1'b0;
        for (int p = 0; p < 16; p++) begin
            if (r_s == johnson_pattern(4'(p))) begin
                w_phase = 4'(p);
                w_legal = 1'b1;
            end
        end
    end

    // Sequencer state, microsecond counter and one-shot error flag.
    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            r_s       <= 8'h00;
            r_us_cnt  <= '0;
            r_seq_err <= 1'b0;
        end else if (CE) begin
            if (SYNC) begin
                // Resync wins over recovery and never counts a cycle.
                r_s       <= c_sync_pat;
                r_seq_err <= 1'b0;
            end else if (!w_legal) begin
                r_s       <= 8'h00;
                r_seq_err <= 1'b1;
            end else begin
                r_s       <= {r_s[6:0], ~r_s[7]};
                r_seq_err <= 1'b0;
                if (w_phase == 4'd15) begin
                    r_us_cnt <= (r_us_cnt == c_us_last) ? '0 : r_us_cnt + 1'b1;
                end
            end
        end else begin
            r_seq_err <= 1'b0;
        end
    end

    assign S         = r_s;
    assign PHASE     = w_phase;
    assign CYC_START = (w_phase == 4'd0) & (r_s == 8'h00) & CE;
    assign US_CNT    = r_us_cnt;
    assign SEQ_ERR   = r_seq_err;

endmodule
`default_nettype wire
